mul_shift_add: RTL and testbench
================================

Name: mul_shift_add

Overview:
- Sequential shift-add multiply-accumulate unit: computes p = a*b + c over WIDTH iterations.
- It is the inverse companion of the restoring divider. Feeding quotient, divisor and remainder back in reconstructs the dividend.
- Uses the same start/busy/ready/count handshake as the divider, so the control FSM drives both units identically.

Parameters:
- WIDTH, 16, operand width; power of two, >= 4.
- CW, $clog2(WIDTH) (localparam), width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  multiplicand; sampled on the start edge.
- b  input  WIDTH  multiplier; sampled on the start edge.
- c  input  WIDTH  addend; sampled on the start edge.
- start  input  1  load operands and begin an operation.
- p  output  2*WIDTH  product/accumulator register.
- busy  output  1  operation in progress.
- ready  output  1  p holds a completed result.
- count  output  CW  iteration index.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk. rst has priority over everything.
- Reset values: p=0, busy=0, ready=0, count=0, internal a register=0.
- Datapath registers:
  - H: WIDTH+1 bits, high half including the carry bit.
  - L: WIDTH bits, low half.
  - A: WIDTH bits, latched multiplicand.
  - p = {H[WIDTH-1:0], L} at all times.
- Start edge (start=1, rst=0):
  - Load H={1'b0,c}, L=b, A=a.
  - busy<=1, ready<=0, count<=0.
  - start is honoured in any state. Asserting start while busy aborts the current operation and restarts with the new operands; no ready pulse is produced for the aborted one.
- Iteration edge (busy=1, start=0):
  - sum = H + (L[0] ? {1'b0,A} : 0), computed WIDTH+1 bits wide.
  - {H,L} <= {sum,L} >> 1 (logical shift; sum's carry enters H's MSB).
  - count <= count+1.
  - When count == WIDTH-1 on this edge: busy<=0 and ready<=1.
- Latency: the start edge is edge 0. The final result is in p and ready=1 after edge WIDTH. busy is high for exactly WIDTH cycles.
- Idle (busy=0, start=0): all registers hold. ready stays 1 until the next start or rst.
- Arithmetic: the result never overflows, since (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W. The unsigned result is exact.
- p is observable mid-operation (partial shifted state), but it is only meaningful when ready=1.
- count wraps naturally from WIDTH-1 to 0 on the final edge.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined: a, b and c are two's complement; c is sign-extended.
  - Iterations 0..WIDTH-2 add A sign-extended to WIDTH+1 bits.
  - The final iteration (count==WIDTH-1) subtracts A when L[0]=1, since b's MSB has negative weight.
  - The shift is arithmetic (H MSB replicated).
  - The result is the exact signed 2*WIDTH value; latency is unchanged.
- Not defined: unsigned behaviour as above; no extra logic.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> p=0, busy=0, ready=0, count=0. Then start with rst=1 simultaneously -> state stays reset.
- Basic product: a=16'h1234, b=16'h5678, c=0, pulse start -> busy=1 for 16 cycles. ready=1 after edge 16 with p=32'h06260060; p holds while idle.
- Max operands: a=b=c=16'hFFFF -> p=32'hFFFF0000, no overflow. Then a=0, b=16'hFFFF, c=16'h0042 -> p=32'h00000042.
- Divider round trip: a=7 (quotient), b=5 (divisor), c=3 (remainder) -> p=32'h00000026 (38). Also check a=0, b=0, c=0 -> p=0, ready after 16 cycles.
- Restart mid-operation: start with a=3, b=3, c=0, then start again at cycle 5 with a=2, b=9, c=1 -> busy stays high continuously. ready rises 16 cycles after the second start with p=19; no intermediate ready.
- Reset mid-operation: rst=1 at iteration 8 -> next edge p=0, busy=0, ready=0, count=0. With MUL_SIGNED_EN: a=16'hFFFF, b=3, c=16'hFFFE -> p=32'hFFFFFFFB (-5).

Source files
------------

// File: rtl/mul_shift_add_if.sv
// Operand/result bundle for mul_shift_add: start/busy/ready/count handshake shared with the divider.
interface mul_shift_add_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   c;
    logic               start;
    logic [2*WIDTH-1:0] p;
    logic               busy;
    logic               ready;
    logic [CW-1:0]      count;

    modport master (
        output a, b, c, start,
        input  p, busy, ready, count
    );

    modport slave (
        input  a, b, c, start,
        output p, busy, ready, count
    );
endinterface

// File: rtl/mul_shift_add.sv
// Sequential shift-add multiply-accumulate, p = a*b + c over WIDTH iterations.
// Define MUL_SIGNED_EN for two's-complement operands (signed addend, subtract on b's MSB, arithmetic shift).
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | holding operands/result; ready marks a valid p
// RUN    | one shift-add iteration per clock, count 0..WIDTH-1
module mul_shift_add #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    mul_shift_add_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   h_q, h_d;
    logic [WIDTH-1:0] l_q, l_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             ready_q, ready_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             last;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic             shift_msb;
    logic [WIDTH:0]   h_load;

    always_comb begin
        last = (cnt_q == CW'(WIDTH - 1));
`ifdef MUL_SIGNED_EN
        // b's MSB carries negative weight, so the final partial product is subtracted
        addend    = l_q[0] ? {a_q[WIDTH-1], a_q} : '0;
        sum       = last ? (h_q - addend) : (h_q + addend);
        shift_msb = sum[WIDTH];
        h_load    = {bus.c[WIDTH-1], bus.c};
`else
        addend    = l_q[0] ? {1'b0, a_q} : '0;
        sum       = h_q + addend;
        shift_msb = 1'b0;
        h_load    = {1'b0, bus.c};
`endif
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        l_d     = l_q;
        a_d     = a_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        if (bus.start) begin
            // a restart while running simply reloads; the aborted result never flags ready
            state_d = ST_RUN;
            h_d     = h_load;
            l_d     = bus.b;
            a_d     = bus.a;
            ready_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            h_d   = {shift_msb, sum[WIDTH:1]};
            l_d   = {sum[0], l_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            l_q     <= '0;
            a_q     <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            l_q     <= l_d;
            a_q     <= a_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.p     = {h_q[WIDTH-1:0], l_q};
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.ready = ready_q;
    assign bus.count = cnt_q;
endmodule

// File: tb/tb_mul_shift_add.sv
// Scoreboard bench for mul_shift_add: expected a*b+c queued at start, checked when ready rises.
module tb_mul_shift_add;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_shift_add_if #(.WIDTH(W)) bus ();
    mul_shift_add #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] sb_q[$];

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c);
`ifdef MUL_SIGNED_EN
        logic signed [2*W-1:0] r;
        r = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}) + $signed({{W{c[W-1]}}, c});
        return r;
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b} + {{W{1'b0}}, c};
`endif
    endfunction

    // Starts an operation, follows busy/count each cycle, then pops and checks the result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input string name, output logic [2*W-1:0] got_exp);
        int k;
        logic [2*W-1:0] exp;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.c = c; bus.start = 1'b1;
        sb_q.push_back(model(a, b, c));
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.ready && k < 40) begin
            total++;
            if (bus.busy !== 1'b1 || bus.count !== k[$clog2(W)-1:0]) begin
                bad++;
                $display("FAIL %s run k=%0d busy=%b count=%0d", name, k, bus.busy, bus.count);
            end
            k++;
            @(negedge clk);
        end
        total++;
        if (k != W) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d", name, k, W);
        end
        exp = '0;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            exp = sb_q.pop_front();
            if (bus.p !== exp) begin
                bad++;
                $display("FAIL %s p got=%h want=%h", name, bus.p, exp);
            end
        end
        total++;
        if (bus.busy !== 1'b0 || bus.count !== '0) begin
            bad++;
            $display("FAIL %s done busy=%b count=%0d want 0/0", name, bus.busy, bus.count);
        end
        got_exp = exp;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.p !== '0 || bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.count !== '0) begin
            bad++;
            $display("FAIL reset p=%h busy=%b ready=%b count=%0d want all 0",
                     bus.p, bus.busy, bus.ready, bus.count);
        end
        bus.a = 16'h0005; bus.b = 16'h0007; bus.c = 16'h0001; bus.start = 1'b1;
        @(negedge clk);
        total++;
        if (bus.p !== '0 || bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.count !== '0) begin
            bad++;
            $display("FAIL reset_with_start p=%h busy=%b ready=%b count=%0d want all 0",
                     bus.p, bus.busy, bus.ready, bus.count);
        end
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [2*W-1:0] exp;
        run_op(16'h1234, 16'h5678, 16'h0000, "basic", exp);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.p !== exp || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL basic_hold cyc=%0d p=%h ready=%b busy=%b want p=%h ready=1 busy=0",
                         i, bus.p, bus.ready, bus.busy, exp);
            end
        end
    endtask

    task automatic test_max();
        logic [2*W-1:0] exp;
        run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, "max_all", exp);
        run_op(16'h0000, 16'hFFFF, 16'h0042, "zero_a", exp);
    endtask

    task automatic test_round_trip();
        logic [2*W-1:0] exp;
        run_op(16'd7, 16'd5, 16'd3, "div_round_trip", exp);
        run_op(16'd0, 16'd0, 16'd0, "all_zero", exp);
    endtask

    task automatic test_restart();
        int k;
        logic [2*W-1:0] exp;
        @(negedge clk);
        bus.a = 16'd3; bus.b = 16'd3; bus.c = 16'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
                bad++;
                $display("FAIL restart_first cyc=%0d busy=%b ready=%b want 1/0", i, bus.busy, bus.ready);
            end
            if (i < 4) @(negedge clk);
        end
        bus.a = 16'd2; bus.b = 16'd9; bus.c = 16'd1; bus.start = 1'b1;
        sb_q.push_back(model(16'd2, 16'd9, 16'd1));
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.ready && k < 40) begin
            total++;
            if (bus.busy !== 1'b1 || bus.count !== k[$clog2(W)-1:0]) begin
                bad++;
                $display("FAIL restart_run k=%0d busy=%b count=%0d", k, bus.busy, bus.count);
            end
            k++;
            @(negedge clk);
        end
        total++;
        if (k != W) begin
            bad++;
            $display("FAIL restart_latency got=%0d want=%0d", k, W);
        end
        exp = sb_q.pop_front();
        total++;
        if (bus.p !== exp) begin
            bad++;
            $display("FAIL restart_p got=%h want=%h", bus.p, exp);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.a = 16'hABCD; bus.b = 16'h1357; bus.c = 16'h2222; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (bus.count !== 4'd8 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre count=%0d busy=%b want 8/1", bus.count, bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.p !== '0 || bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.count !== '0) begin
            bad++;
            $display("FAIL reset_mid p=%h busy=%b ready=%b count=%0d want all 0",
                     bus.p, bus.busy, bus.ready, bus.count);
        end
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.p !== '0) begin
            bad++;
            $display("FAIL reset_mid_idle busy=%b ready=%b p=%h want 0/0/0", bus.busy, bus.ready, bus.p);
        end
    endtask

`ifdef MUL_SIGNED_EN
    task automatic test_signed();
        logic [2*W-1:0] exp;
        run_op(16'hFFFF, 16'h0003, 16'hFFFE, "signed_neg", exp);
        run_op(16'h8000, 16'h8000, 16'h8000, "signed_min", exp);
        run_op(16'h0007, 16'hFFF9, 16'h0010, "signed_mixed", exp);
    endtask
`endif

    task automatic test_back_to_back();
        logic [2*W-1:0] exp;
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), W'($urandom), "b2b_rand", exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0;
        test_reset();
        test_basic();
        test_max();
        test_round_trip();
        test_restart();
        test_reset_mid();
`ifdef MUL_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
